// File: rtl/ctrl_pwm_driver.sv
// Complementary PWM driver: PID sample clamp, slew-limited duty, period counter
// and a dead-time-inserting high/low output FSM.
module ctrl_pwm_driver #(
    parameter int unsigned DEADTIME = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] control_signal,
    input  logic               ctrl_valid,
    input  logic               enable,
    input  logic        [15:0] period,
    input  logic        [15:0] bias,
    input  logic        [15:0] slew_step,
    output logic               pwm_hi,
    output logic               pwm_lo,
    output logic        [15:0] duty,
    output logic        [1:0]  sat,
    output logic               period_start
);

    localparam int unsigned W   = 16;
    localparam int unsigned SW  = 18;
    localparam int unsigned DTW = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HI    = 3'd1,
        DT_LO = 3'd2,
        LO    = 3'd3,
        DT_HI = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [DTW-1:0]   dt_q, dt_d;
    logic [W-1:0]     cnt_q, cnt_d;
    logic [W-1:0]     duty_q, duty_d;
    logic [W-1:0]     target_q, target_d;
    logic [W-1:0]     plat_q, plat_d;
    logic [1:0]       sat_q, sat_d;
    logic             run_q;
    logic             pwm_hi_q, pwm_hi_d;
    logic             pwm_lo_q, pwm_lo_d;
    logic             ps_q, ps_d;

    logic             run_c, rise_c, wrap_c, load_c, raw_c;
    logic signed [SW-1:0] sum_c, lim_c;
    logic [W-1:0]     clamp_c, diff_c, step_c, slewed_c;
    logic [1:0]       sat_c;

    assign run_c  = enable && (period >= 16'd2);
    assign rise_c = run_c && !run_q;
    assign wrap_c = run_c && run_q && (cnt_q >= plat_q - 16'd1);
    assign load_c = rise_c || wrap_c;
    assign raw_c  = cnt_q < duty_q;

    // Controller sample: bias + signed control, clamped to the latched period
    always_comb begin
        sum_c   = $signed({2'b00, bias}) + SW'(control_signal);
        lim_c   = $signed({2'b00, plat_q});
        clamp_c = W'(sum_c);
        sat_c   = 2'b00;
        if (sum_c > lim_c) begin
            clamp_c = plat_q;
            sat_c   = 2'b10;
        end else if (sum_c < 18'sd0) begin
            clamp_c = '0;
            sat_c   = 2'b01;
        end
    end

    // Duty moves toward the (pre-sample) target by at most slew_step per load
    always_comb begin
        diff_c   = (target_q > duty_q) ? (target_q - duty_q) : (duty_q - target_q);
        step_c   = (diff_c > slew_step) ? slew_step : diff_c;
        slewed_c = target_q;
        if (slew_step != '0) begin
            slewed_c = (target_q > duty_q) ? (duty_q + step_c) : (duty_q - step_c);
        end
    end

    always_comb begin
        target_d = target_q;
        sat_d    = sat_q;
        cnt_d    = cnt_q;
        duty_d   = duty_q;
        plat_d   = plat_q;
        ps_d     = 1'b0;
        if (ctrl_valid) begin
            target_d = clamp_c;
            sat_d    = sat_c;
        end
        if (!run_c) begin
            cnt_d  = '0;
            duty_d = '0;
        end else if (load_c) begin
            cnt_d  = '0;
            plat_d = period;
            duty_d = (slewed_c > period) ? period : slewed_c;
            ps_d   = 1'b1;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dt_q     <= '0;
            cnt_q    <= '0;
            duty_q   <= '0;
            target_q <= '0;
            plat_q   <= '0;
            sat_q    <= '0;
            run_q    <= 1'b0;
            pwm_hi_q <= 1'b0;
            pwm_lo_q <= 1'b0;
            ps_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            dt_q     <= dt_d;
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            plat_q   <= plat_d;
            sat_q    <= sat_d;
            run_q    <= run_c;
            pwm_hi_q <= pwm_hi_d;
            pwm_lo_q <= pwm_lo_d;
            ps_q     <= ps_d;
        end
    end

    // Next state: a raw change during dead time flips direction and restarts the count
    always_comb begin
        state_d = state_q;
        dt_d    = dt_q;
        if (!run_c) begin
            state_d = IDLE;
            dt_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run_q) begin
                        state_d = raw_c ? DT_HI : DT_LO;
                        dt_d    = '0;
                    end
                end
                HI: begin
                    if (!raw_c) begin
                        state_d = DT_LO;
                        dt_d    = '0;
                    end
                end
                LO: begin
                    if (raw_c) begin
                        state_d = DT_HI;
                        dt_d    = '0;
                    end
                end
                DT_LO: begin
                    if (raw_c) begin
                        state_d = DT_HI;
                        dt_d    = '0;
                    end else if (dt_q == DTW'(DEADTIME - 1)) begin
                        state_d = LO;
                        dt_d    = '0;
                    end else begin
                        dt_d = dt_q + 8'd1;
                    end
                end
                DT_HI: begin
                    if (!raw_c) begin
                        state_d = DT_LO;
                        dt_d    = '0;
                    end else if (dt_q == DTW'(DEADTIME - 1)) begin
                        state_d = HI;
                        dt_d    = '0;
                    end else begin
                        dt_d = dt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    dt_d    = '0;
                end
            endcase
        end
    end

    // Drive decode from the next state so the registered outputs track state_q
    always_comb begin
        pwm_hi_d = 1'b0;
        pwm_lo_d = 1'b0;
        if (state_d == HI) pwm_hi_d = 1'b1;
        if (state_d == LO) pwm_lo_d = 1'b1;
    end

    assign pwm_hi       = pwm_hi_q;
    assign pwm_lo       = pwm_lo_q;
    assign duty         = duty_q;
    assign sat          = sat_q;
    assign period_start = ps_q;

endmodule
